// File: rtl/mole_scorer.sv
// Whack-a-mole scorer: synchronizes the player buttons, matches presses against the lit mole,
// and keeps a BCD hit score and a binary miss count that ends the game at MISS_LIMIT.
module mole_scorer #(
  parameter int unsigned MISS_LIMIT = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pulse,
  input  logic [4:0] mole_position,
  input  logic [4:0] buttons,
  output logic [7:0] score,
  output logic [3:0] misses,
  output logic [4:0] mole_visible,
  output logic       hit_strobe,
  output logic       game_over
);

  localparam int unsigned N_MOLES  = 5;
  localparam int unsigned SCORE_W  = 8;
  localparam int unsigned MISS_W   = 4;
  localparam int unsigned WARM_W   = 2;
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(15);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(8'h99);
  localparam logic [WARM_W-1:0]  WARM_DONE = WARM_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ARMED  = 2'd2,
    HIT    = 2'd3
  } state_t;

  state_t              state;
  logic                enable_q;
  logic [N_MOLES-1:0]  sync_meta;
  logic [N_MOLES-1:0]  sync_out;
  logic [N_MOLES-1:0]  sync_prev;
  logic [WARM_W-1:0]   warm;
  logic [N_MOLES-1:0]  btn_edge;
  logic                hit;
  logic                wrong_press;
  logic                escape;

  // Button synchronizer and edge history; edges stay masked until the history has refilled
  // after reset so a button already held at release never looks like a fresh press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sync_out  <= '0;
      sync_prev <= '0;
      warm      <= '0;
    end else begin
      sync_meta <= buttons;
      sync_out  <= sync_meta;
      sync_prev <= sync_out;
      if (warm != WARM_DONE) warm <= warm + WARM_W'(1);
    end
  end

  assign btn_edge    = (warm == WARM_DONE) ? (sync_out & ~sync_prev) : '0;
  assign hit         = (btn_edge == mole_position) && (mole_position != '0);
  assign wrong_press = (btn_edge != '0) && !hit;
  assign escape      = pulse && (mole_position != '0);

  assign game_over    = (misses >= MISS_W'(MISS_LIMIT));
  assign mole_visible = (!game_over && (state == ARMED || state == SETTLE)) ? mole_position : '0;

  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
    if (s == SCORE_MAX)       bcd_inc = s;
    else if (s[3:0] == 4'd9)  bcd_inc = {s[7:4] + 4'd1, 4'd0};
    else                      bcd_inc = {s[7:4], s[3:0] + 4'd1};
  endfunction

  function automatic logic [MISS_W-1:0] miss_inc(input logic [MISS_W-1:0] m);
    miss_inc = (m == MISS_MAX) ? m : m + MISS_W'(1);
  endfunction

  // Game FSM with registered counters; enable_q resets high so a live enable at reset
  // release is not mistaken for a new game start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      enable_q   <= 1'b1;
      score      <= '0;
      misses     <= '0;
      hit_strobe <= 1'b0;
    end else begin
      enable_q   <= enable;
      hit_strobe <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else if (!enable_q) begin
        score  <= '0;
        misses <= '0;
        state  <= SETTLE;
      end else if (game_over) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:   state <= IDLE;
          SETTLE: state <= ARMED;
          ARMED: begin
            if (hit) begin
              score      <= bcd_inc(score);
              hit_strobe <= 1'b1;
              state      <= pulse ? SETTLE : HIT;
            end else begin
              // A wrong press and an escape in the same cycle still cost only one miss.
              if (wrong_press || escape) misses <= miss_inc(misses);
              if (pulse) state <= SETTLE;
            end
          end
          HIT:     if (pulse) state <= SETTLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/mole_scorer.md
MOLE_SCORER -- requirements
Module: mole_scorer

Interface
REQ-001 Parameter: MISS_LIMIT, default 9, miss count at which game_over asserts (legal range 1..15).
REQ-002 Port: clock  input  1  100 MHz system clock.
REQ-003 Port: reset  input  1  reset, asynchronous, active-low.
REQ-004 Port: enable  input  1  game-running level, shared with mole_generator.
REQ-005 Port: pulse  input  1  one-cycle new-mole strobe, same signal that drives mole_generator.
REQ-006 Port: mole_position  input  5  one-hot lit mole from mole_generator; 0 = no mole.
REQ-007 Port: buttons  input  5  raw, asynchronous, debounced player buttons; bit i pairs with mole i.
REQ-008 Port: score  output  8  two-digit BCD hit count, {tens,ones}.
REQ-009 Port: misses  output  4  binary miss count.
REQ-010 Port: mole_visible  output  5  mole_position masked off once the current mole is hit.
REQ-011 Port: hit_strobe  output  1  one-cycle pulse per registered hit.
REQ-012 Port: game_over  output  1  level, high while misses >= MISS_LIMIT.

Function
REQ-013 Each buttons bit SHALL pass a 2-flop synchronizer and then a rising-edge detector. The edge vector SHALL be high for exactly one cycle per press.
REQ-014 A raw press sampled at clock edge k SHALL produce an edge in the cycle after edge k+1. The resulting counter change SHALL be visible after edge k+2.
REQ-015 The FSM SHALL have the states IDLE, SETTLE, ARMED and HIT.
REQ-016 IDLE: entered when enable=0 and on reset. All inputs are ignored and counters hold. On enable 0->1, the block SHALL clear score and misses and go to SETTLE.
REQ-017 SETTLE: lasts exactly one cycle, so the registered mole_position update can land. Edges arriving in this cycle SHALL be discarded. The next state is ARMED.
REQ-018 ARMED, edge vector == mole_position and mole_position != 0: the block SHALL increment score, pulse hit_strobe, and go to HIT.
REQ-019 ARMED, edge vector nonzero and not equal to mole_position, including multi-button presses and any press while mole_position == 0: misses SHALL increment by exactly 1 per cycle, and the state stays ARMED.
REQ-020 ARMED, pulse with no qualifying hit in that cycle: if mole_position != 0, misses SHALL increment by 1 (escaped mole). The next state is SETTLE.
REQ-021 Simultaneous correct edge and pulse in ARMED: the hit wins. Score increments, no escape miss is counted, and the next state is SETTLE.
REQ-022 Simultaneous wrong edge and pulse in ARMED: misses SHALL increment by 1 only, not 2.
REQ-023 HIT: all edges are ignored. On pulse the next state is SETTLE.
REQ-024 enable=0 in any state SHALL force IDLE on the next edge. Counters hold their values.
REQ-025 Score SHALL be BCD: ones wraps 9->0 with a carry into tens. The score saturates at 0x99.
REQ-026 misses SHALL saturate at 15.
REQ-027 game_over SHALL be combinational from misses.
REQ-028 While game_over=1, the FSM SHALL behave as IDLE without clearing counters, until enable goes 0 and then returns 1.
REQ-029 mole_visible SHALL equal mole_position in ARMED and SETTLE, and 0 in HIT, IDLE and while game_over=1.
REQ-030 All state, counters, synchronizers and edge history SHALL update only on the rising edge of clock.

Reset
REQ-031 reset low SHALL asynchronously set: state = IDLE, score = 0x00, misses = 0, hit_strobe = 0, synchronizer and edge history = 0.
REQ-032 With reset low, mole_visible = 0 and game_over = 0 (given MISS_LIMIT >= 1).
REQ-033 Reset released mid-game SHALL leave the block in IDLE. A fresh enable 0->1 is required before scoring.
REQ-034 Buttons held low-to-high across reset release SHALL produce an edge. Buttons already high at release SHALL NOT produce an edge.

Verification
REQ-035 enable 0->1, pulse, mole_position=5'b00100, raw buttons[2] rises -> score=0x01 three edges later, hit_strobe one cycle, mole_visible=0.
REQ-036 Mole 5'b00001 lit, buttons[3] pressed -> misses=1, score unchanged, state stays ARMED. Then buttons[0] pressed -> score increments.
REQ-037 Mole lit, no press, next pulse -> misses increments by 1. A correct edge coincident with that pulse -> score+1, misses unchanged.
REQ-038 100 consecutive hits from score 0x98 -> 0x99 then holds 0x99. Nine misses with MISS_LIMIT=9 -> game_over=1, mole_visible=0, further presses ignored.
REQ-039 reset pulsed low mid-game with score=0x42, misses=3 -> immediate 0x00 and 0. Presses ignored until enable toggles 0->1.
